// File: rtl/register_file.sv
// ---------------------------------------------------------------------------
// register_file
//   Eight 16-bit architectural registers R0-R7. R7 is the program counter.
//   Each register also has a 2-bit pending-writer scoreboard counter. Decode
//   reserves a destination with alloc_en, and Write_Back releases it with
//   wb_en.
//
//   Build option: define RF_BYPASS_EN to enable write-to-read bypass. When it
//   is enabled, a read of the register being committed returns wb_data in the
//   same cycle, and its busy flag ignores the committing writer.
//
// Ports
//   clk                    rising-edge clock for all state
//   resetn                 synchronous active-low reset
//   wb_en/wb_addr/wb_data  write-back commit (also releases a reservation)
//   rd_addr_a/b            read-port selects
//   rd_data_a/b            read-port data
//   busy_a/b               selected register has an outstanding writer
//   alloc_en/alloc_addr    decode reserves a destination register
//   pc_we/pc_next          sequential or branch update of R7
//   pc_out                 current R7 value
//   pend_ovf               sticky flag: a pending counter over/underflowed
// ---------------------------------------------------------------------------
module register_file #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_en,
  input  logic [2:0]  wb_addr,
  input  logic [15:0] wb_data,
  input  logic [2:0]  rd_addr_a,
  input  logic [2:0]  rd_addr_b,
  output logic [15:0] rd_data_a,
  output logic [15:0] rd_data_b,
  output logic        busy_a,
  output logic        busy_b,
  input  logic        alloc_en,
  input  logic [2:0]  alloc_addr,
  input  logic        pc_we,
  input  logic [15:0] pc_next,
  output logic [15:0] pc_out,
  output logic        pend_ovf
);

  localparam logic [2:0] PC_IDX = 3'd7;

  logic [15:0] regs [8];
  logic [1:0]  pend [8];
  logic        ovf_q;

  // One-hot per-register increment/decrement requests for this edge.
  logic [7:0] inc_vec;
  logic [7:0] dec_vec;

  // NOTE: every output of a combinational block gets a default before any
  // conditional assignment, so no path can leave it unassigned and infer a latch.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (alloc_en) inc_vec[alloc_addr] = 1'b1;
    if (wb_en)    dec_vec[wb_addr]    = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples its pre-edge value regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: this storage is built from flops and must come up in a known state
      // (R7 = RESET_PC, nothing pending), so it is reset, unlike a RAM macro.
      for (int i = 0; i < 8; i++) begin
        regs[i] <= 16'h0000;
        pend[i] <= 2'd0;
      end
      regs[PC_IDX] <= RESET_PC;
      ovf_q        <= 1'b0;
    end else begin
      if (wb_en) regs[wb_addr] <= wb_data;
      // A commit to R7 outranks the PC update in the same cycle.
      if (pc_we && !(wb_en && wb_addr == PC_IDX)) regs[PC_IDX] <= pc_next;

      for (int i = 0; i < 8; i++) begin
        // When both events hit the same register, they cancel and the count is unchanged.
        if (inc_vec[i] && !dec_vec[i]) begin
          if (pend[i] == 2'd3) ovf_q   <= 1'b1;
          else                 pend[i] <= pend[i] + 2'd1;
        end else if (dec_vec[i] && !inc_vec[i]) begin
          if (pend[i] == 2'd0) ovf_q   <= 1'b1;
          else                 pend[i] <= pend[i] - 2'd1;
        end
      end
    end
  end

  always_comb begin
    rd_data_a = regs[rd_addr_a];
    rd_data_b = regs[rd_addr_b];
    busy_a    = (pend[rd_addr_a] != 2'd0);
    busy_b    = (pend[rd_addr_b] != 2'd0);
`ifdef RF_BYPASS_EN
    // A committing writer is already done. Busy reflects the post-decrement
    // count, which stays nonzero only if other writers remain.
    if (resetn && wb_en && wb_addr == rd_addr_a) begin
      rd_data_a = wb_data;
      busy_a    = (pend[rd_addr_a] > 2'd1);
    end
    if (resetn && wb_en && wb_addr == rd_addr_b) begin
      rd_data_b = wb_data;
      busy_b    = (pend[rd_addr_b] > 2'd1);
    end
`else
    // Reads return stored state only. A commit becomes visible on the next cycle.
`endif
  end

  assign pc_out   = regs[PC_IDX];
  assign pend_ovf = ovf_q;

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file. A behavioural model (plain arrays and
// integer arithmetic) is compared against all outputs on every cycle.
module tb_register_file;

  localparam logic [15:0] RST_PC = 16'h0010;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [15:0] wb_data;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [15:0] rd_data_a, rd_data_b;
  logic        busy_a, busy_b;
  logic        alloc_en;
  logic [2:0]  alloc_addr;
  logic        pc_we;
  logic [15:0] pc_next;
  logic [15:0] pc_out;
  logic        pend_ovf;

  always #5 clk = ~clk;

  register_file #(.RESET_PC(RST_PC)) dut (
    .clk(clk), .resetn(resetn),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .busy_a(busy_a), .busy_b(busy_b),
    .alloc_en(alloc_en), .alloc_addr(alloc_addr),
    .pc_we(pc_we), .pc_next(pc_next),
    .pc_out(pc_out), .pend_ovf(pend_ovf)
  );

  // Reference model state
  int unsigned m_reg [8];
  int          m_cnt [8];
  bit          m_ovf;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, got, exp);
  endtask

  function automatic bit bypass_hit(input logic [2:0] a);
`ifdef RF_BYPASS_EN
    return resetn && wb_en && wb_addr == a;
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] exp_rd(input logic [2:0] a);
    if (bypass_hit(a)) return wb_data;
    return m_reg[a][15:0];
  endfunction

  function automatic logic exp_busy(input logic [2:0] a);
    if (bypass_hit(a)) return (m_cnt[a] - 1) > 0;
    return m_cnt[a] > 0;
  endfunction

  // Advance the model by one rising edge using the inputs currently applied.
  task automatic model_edge();
    if (!resetn) begin
      for (int i = 0; i < 8; i++) begin m_reg[i] = 0; m_cnt[i] = 0; end
      m_reg[7] = RST_PC;
      m_ovf = 0;
    end else begin
      int nxt7;
      nxt7 = m_reg[7];
      if (pc_we) nxt7 = pc_next;
      if (wb_en) m_reg[wb_addr] = wb_data;
      if (wb_en && wb_addr == 3'd7) nxt7 = wb_data;
      m_reg[7] = nxt7;
      for (int i = 0; i < 8; i++) begin
        int n;
        n = m_cnt[i] + ((alloc_en && alloc_addr == i) ? 1 : 0)
                     - ((wb_en && wb_addr == i) ? 1 : 0);
        if (n > 3) begin n = 3; m_ovf = 1; end
        if (n < 0) begin n = 0; m_ovf = 1; end
        m_cnt[i] = n;
      end
    end
  endtask

  task automatic idle();
    resetn = 1'b1; wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'h0;
    alloc_en = 1'b0; alloc_addr = 3'd0; pc_we = 1'b0; pc_next = 16'h0;
  endtask

  // Check all outputs midway through the cycle, then clock the DUT and the model together.
  task automatic step(input string tag);
    @(negedge clk);
    check({tag, ".rd_a"},   rd_data_a, exp_rd(rd_addr_a));
    check({tag, ".rd_b"},   rd_data_b, exp_rd(rd_addr_b));
    check({tag, ".busy_a"}, {15'd0, busy_a}, {15'd0, exp_busy(rd_addr_a)});
    check({tag, ".busy_b"}, {15'd0, busy_b}, {15'd0, exp_busy(rd_addr_b)});
    check({tag, ".pc"},     pc_out, m_reg[7][15:0]);
    check({tag, ".ovf"},    {15'd0, pend_ovf}, {15'd0, m_ovf});
    @(posedge clk);
    model_edge();
    #1;
  endtask

  initial begin
    idle();
    rd_addr_a = 3'd3; rd_addr_b = 3'd7;
    resetn = 1'b0;
    @(posedge clk); model_edge(); #1;
    resetn = 1'b1;

    // Reset state
    step("reset");
    check("reset.pc_const", pc_out, 16'h0010);
    check("reset.rd3_const", rd_data_a, 16'h0000);

    // Commit BEEF to R2 while reading R2
    rd_addr_a = 3'd2;
    wb_en = 1'b1; wb_addr = 3'd2; wb_data = 16'hBEEF;
    step("wb_r2");
    idle();
    step("wb_r2_next");
    check("wb_r2.const", rd_data_a, 16'hBEEF);

    // R7 commit beats pc_we
    wb_en = 1'b1; wb_addr = 3'd7; wb_data = 16'h0100;
    pc_we = 1'b1; pc_next = 16'h0021;
    step("pc_prio");
    idle();
    step("pc_prio_next");
    check("pc_prio.const", pc_out, 16'h0100);

    // Four allocations to R4 saturate and set the overflow flag, then three commits drain it
    rd_addr_a = 3'd4;
    for (int k = 0; k < 4; k++) begin
      alloc_en = 1'b1; alloc_addr = 3'd4;
      step("alloc_r4");
    end
    idle();
    step("alloc_r4_sat");
    check("alloc_r4.ovf_const", {15'd0, pend_ovf}, 16'h0001);
    for (int k = 0; k < 3; k++) begin
      wb_en = 1'b1; wb_addr = 3'd4; wb_data = 16'h4000 + 16'(k);
      step("drain_r4");
    end
    idle();
    step("drain_r4_done");
    check("drain_r4.busy_const", {15'd0, busy_a}, 16'h0000);

    // Simultaneous alloc and commit to R5 at count 1
    rd_addr_b = 3'd5;
    alloc_en = 1'b1; alloc_addr = 3'd5;
    step("r5_alloc");
    alloc_en = 1'b1; alloc_addr = 3'd5; wb_en = 1'b1; wb_addr = 3'd5; wb_data = 16'h5555;
    step("r5_both");
    idle();
    step("r5_after");
    check("r5.busy_const", {15'd0, busy_b}, 16'h0001);

    // A reset in mid-operation discards reservations; a later commit then underflows
    rd_addr_a = 3'd1;
    alloc_en = 1'b1; alloc_addr = 3'd1; pc_we = 1'b1; pc_next = 16'h0040;
    step("r1_alloc0");
    pc_we = 1'b0;
    step("r1_alloc1");
    idle();
    step("r1_busy");
    resetn = 1'b0;
    @(posedge clk); model_edge(); #1;
    resetn = 1'b1;
    step("r1_after_reset");
    check("r1.pc_const", pc_out, RST_PC);
    wb_en = 1'b1; wb_addr = 3'd1; wb_data = 16'h1111;
    step("r1_wb");
    idle();
    step("r1_ovf");
    check("r1.ovf_const", {15'd0, pend_ovf}, 16'h0001);

    // Randomized traffic
    for (int k = 0; k < 400; k++) begin
      resetn     = ($urandom_range(0, 49) != 0);
      wb_en      = $urandom_range(0, 1) == 1;
      wb_addr    = 3'($urandom_range(0, 7));
      wb_data    = 16'($urandom);
      alloc_en   = $urandom_range(0, 1) == 1;
      alloc_addr = 3'($urandom_range(0, 7));
      pc_we      = $urandom_range(0, 2) == 0;
      pc_next    = 16'($urandom);
      rd_addr_a  = 3'($urandom_range(0, 7));
      rd_addr_b  = 3'($urandom_range(0, 7));
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 Parameter: RESET_PC, default 16'h0000, value loaded into R7 (program counter) on reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 resetn  input  1  reset, synchronous, active-low.
REQ-004 wb_en  input  1  write-back commit strobe from the Write_Back stage.
REQ-005 wb_addr  input  3  destination register of the commit.
REQ-006 wb_data  input  16  value to commit.
REQ-007 rd_addr_a, rd_addr_b  input  3 each  read-port selects.
REQ-008 rd_data_a, rd_data_b  output  16 each  read-port data.
REQ-009 busy_a, busy_b  output  1 each  selected register has an outstanding writer.
REQ-010 alloc_en, alloc_addr  input  1, 3  decode reserves a destination register.
REQ-011 pc_we, pc_next  input  1, 16  sequential or branch update of R7.
REQ-012 pc_out  output  16  current R7 value.
REQ-013 pend_ovf  output  1  sticky flag: a pending counter overflowed.

Function
REQ-014 Storage: eight 16-bit registers R0-R7; R7 is the PC.
REQ-015 Reads are combinational from current state; rd_addr of 7 returns the R7 value.
REQ-016 Writes take effect on the rising clk edge; new values are visible to reads in the following cycle.
REQ-017 wb_en=1 writes wb_data into R[wb_addr]; R0 has no special treatment and is writable.
REQ-018 R7 priority at an edge: wb_en with wb_addr=7 beats pc_we; pc_we alone loads pc_next; neither holds R7.
REQ-019 pc_out always equals R7.
REQ-020 Scoreboard: one 2-bit pending counter per register.
REQ-021 Counter update per edge: increment on alloc_en to that address; decrement on wb_en to that address; both to the same address leaves it unchanged.
REQ-022 An increment at count 3 holds the count at 3 and sets pend_ovf.
REQ-023 A decrement at count 0 holds the count at 0 and sets pend_ovf.
REQ-024 busy_x is 1 when the counter of rd_addr_x is nonzero (subject to REQ-031).
REQ-025 Events to different addresses in the same cycle (alloc, wb, pc_we) all take effect independently.
REQ-026 pend_ovf clears only on reset.

Reset
REQ-027 When resetn=0 at a rising edge: R0-R6 become 16'h0000, R7 becomes RESET_PC, all pending counters become 0, and pend_ovf becomes 0.
REQ-028 During any reset cycle, wb_en, alloc_en and pc_we are ignored; reset mid-operation discards all in-flight reservations.
REQ-029 In the cycle after reset: rd_data of every register except R7 reads 0, busy_a=busy_b=0, pc_out=RESET_PC.

Configuration
REQ-030 Macro RF_BYPASS_EN selects write-to-read bypass.
REQ-031 With RF_BYPASS_EN defined, when wb_en=1 and wb_addr=rd_addr_x:
  - rd_data_x returns wb_data in the same cycle;
  - busy_x is computed from the post-decrement count, i.e. it excludes the committing writer.
REQ-032 Without RF_BYPASS_EN, reads return stored state only and the commit is visible one cycle later.

Verification
REQ-033 Reset with RESET_PC=16'h0010 -> pc_out=16'h0010, rd_data_a=0 for addr 3, busy_a=0, pend_ovf=0.
REQ-034 wb_en=1, wb_addr=2, wb_data=16'hBEEF, rd_addr_a=2 -> without bypass, rd_data_a is old value then 16'hBEEF next cycle; with RF_BYPASS_EN, 16'hBEEF in the same cycle.
REQ-035 Same cycle wb_en/wb_addr=7/wb_data=16'h0100 and pc_we/pc_next=16'h0021 -> pc_out=16'h0100 next cycle.
REQ-036 Four alloc_en to R4 with no commits -> count saturates at 3, busy=1, pend_ovf=1; then three wb to R4 -> busy=0.
REQ-037 alloc_en and wb_en both to R5 in the same cycle with count 1 -> count remains 1, busy stays 1.
REQ-038 Count 2 on R1 and pc=16'h0040, then resetn=0 for one cycle -> busy=0 and pc_out=RESET_PC after reset; a wb to R1 then sets pend_ovf.
